prgrom_arbiter: RTL and testbench

PRGROM_ARBITER -- requirements
Module: prgrom_arbiter

---
 rtl/prgrom_arbiter.sv | 157 +++++++++++++++
 tb/tb_prgrom_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prgrom_arbiter.sv
// prgrom_arbiter
// Shares one synchronous program ROM port between a main CPU (MC), a sound
// CPU (SC) and a one-entry download write buffer.
//
// Ports:
//   CLK48M            - sole clock, all state changes on its rising edge
//   RESET             - asynchronous, active-high reset
//   MC_REQ/MC_AD      - main-CPU 4-phase read request and address (M1 in MSB)
//   MC_ACK/MC_DT      - main-CPU read complete (level) and held read data
//   SC_REQ/SC_AD      - sound-CPU 4-phase read request and address
//   SC_ACK/SC_DT      - sound-CPU read complete (level) and held read data
//   DL_WR/DL_AD/DL_DT - download byte strobe, address and data
//   DL_BUSY           - download buffer occupied
//   DL_OVF            - sticky: a download byte was dropped
//   ROM_AD/ROM_WE/ROM_WD - registered shared ROM address, write enable, data
//   ROM_RD            - ROM read data, valid one cycle after ROM_AD
module prgrom_arbiter #(
  parameter int AW = 16
) (
  input  logic          CLK48M,
  input  logic          RESET,
  input  logic          MC_REQ,
  input  logic [AW-1:0] MC_AD,
  output logic          MC_ACK,
  output logic [7:0]    MC_DT,
  input  logic          SC_REQ,
  input  logic [AW-1:0] SC_AD,
  output logic          SC_ACK,
  output logic [7:0]    SC_DT,
  input  logic          DL_WR,
  input  logic [AW-1:0] DL_AD,
  input  logic [7:0]    DL_DT,
  output logic          DL_BUSY,
  output logic          DL_OVF,
  output logic [AW-1:0] ROM_AD,
  output logic          ROM_WE,
  output logic [7:0]    ROM_WD,
  input  logic [7:0]    ROM_RD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CAPT  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_mcAck;
  logic          r_scAck;
  logic [7:0]    r_mcDt;
  logic [7:0]    r_scDt;
  logic [AW-1:0] r_romAd;
  logic          r_romWe;
  logic [7:0]    r_romWd;
  logic          r_selSc;
  logic          r_lastSc;
  logic          r_bufFull;
  logic [AW-1:0] r_bufAd;
  logic [7:0]    r_bufDt;
  logic          r_ovf;

  logic w_mcPend;
  logic w_scPend;
  logic w_pickSc;
  logic w_dlGrant;

  // A requester is pending only until its ACK rises; it must drop REQ and
  // see ACK clear before it can ask again.
  assign w_mcPend  = MC_REQ & ~r_mcAck;
  assign w_scPend  = SC_REQ & ~r_scAck;
  // On a tie, serve whoever was not served last.
  assign w_pickSc  = w_scPend & (~w_mcPend | ~r_lastSc);
  assign w_dlGrant = (r_state == IDLE) & r_bufFull;

  // Arbitration FSM: IDLE grants the download buffer first, then reads.
  // A write takes IDLE+WRITE, a read takes IDLE+READ+CAPT.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_mcAck  <= 1'b0;
      r_scAck  <= 1'b0;
      r_mcDt   <= 8'h00;
      r_scDt   <= 8'h00;
      r_romAd  <= '0;
      r_romWe  <= 1'b0;
      r_romWd  <= 8'h00;
      r_selSc  <= 1'b0;
      r_lastSc <= 1'b1;
    end else begin
      r_romWe <= 1'b0;
      if (!MC_REQ) r_mcAck <= 1'b0;
      if (!SC_REQ) r_scAck <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_bufFull) begin
            r_romAd <= r_bufAd;
            r_romWd <= r_bufDt;
            r_romWe <= 1'b1;
            r_state <= WRITE;
          end else if (w_mcPend | w_scPend) begin
            r_romAd  <= w_pickSc ? SC_AD : MC_AD;
            r_selSc  <= w_pickSc;
            r_lastSc <= w_pickSc;
            r_state  <= READ;
          end
        end
        WRITE: r_state <= IDLE;
        READ:  r_state <= CAPT;
        CAPT: begin
          if (r_selSc) begin
            r_scDt  <= ROM_RD;
            r_scAck <= 1'b1;
          end else begin
            r_mcDt  <= ROM_RD;
            r_mcAck <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // One-entry download buffer. A byte arriving on the grant edge replaces
  // the one being handed to the ROM; otherwise a byte arriving while full
  // is dropped and flagged.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      r_bufFull <= 1'b0;
      r_bufAd   <= '0;
      r_bufDt   <= 8'h00;
      r_ovf     <= 1'b0;
    end else if (DL_WR) begin
      if (!r_bufFull || w_dlGrant) begin
        r_bufFull <= 1'b1;
        r_bufAd   <= DL_AD;
        r_bufDt   <= DL_DT;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (w_dlGrant) begin
      r_bufFull <= 1'b0;
    end
  end

  assign MC_ACK  = r_mcAck;
  assign MC_DT   = r_mcDt;
  assign SC_ACK  = r_scAck;
  assign SC_DT   = r_scDt;
  assign DL_BUSY = r_bufFull;
  assign DL_OVF  = r_ovf;
  assign ROM_AD  = r_romAd;
  assign ROM_WE  = r_romWe;
  assign ROM_WD  = r_romWd;

endmodule

// File: tb/tb_prgrom_arbiter.sv
// tb_prgrom_arbiter
// Directed bench for prgrom_arbiter with a small synchronous ROM model
// (1-cycle read latency) and hand-computed expectations.
module tb_prgrom_arbiter;

  logic        CLK48M;
  logic        RESET;
  logic        MC_REQ;
  logic [15:0] MC_AD;
  logic        MC_ACK;
  logic [7:0]  MC_DT;
  logic        SC_REQ;
  logic [15:0] SC_AD;
  logic        SC_ACK;
  logic [7:0]  SC_DT;
  logic        DL_WR;
  logic [15:0] DL_AD;
  logic [7:0]  DL_DT;
  logic        DL_BUSY;
  logic        DL_OVF;
  logic [15:0] ROM_AD;
  logic        ROM_WE;
  logic [7:0]  ROM_WD;
  logic [7:0]  ROM_RD;

  logic [7:0] romMem [0:65535];

  int compared;
  int mismatched;

  prgrom_arbiter #(.AW(16)) dut (
    .CLK48M (CLK48M),
    .RESET  (RESET),
    .MC_REQ (MC_REQ),
    .MC_AD  (MC_AD),
    .MC_ACK (MC_ACK),
    .MC_DT  (MC_DT),
    .SC_REQ (SC_REQ),
    .SC_AD  (SC_AD),
    .SC_ACK (SC_ACK),
    .SC_DT  (SC_DT),
    .DL_WR  (DL_WR),
    .DL_AD  (DL_AD),
    .DL_DT  (DL_DT),
    .DL_BUSY(DL_BUSY),
    .DL_OVF (DL_OVF),
    .ROM_AD (ROM_AD),
    .ROM_WE (ROM_WE),
    .ROM_WD (ROM_WD),
    .ROM_RD (ROM_RD)
  );

  // 48 MHz-ish clock; exact period is irrelevant to the design.
  initial CLK48M = 1'b0;
  always #5 CLK48M = ~CLK48M;

  // Synchronous ROM: data for the registered address appears one edge later.
  always @(posedge CLK48M) ROM_RD <= romMem[ROM_AD];

  // Advance n rising edges and settle just after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) @(posedge CLK48M);
    #1;
  endtask

  // Count one comparison and report it if the DUT disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Pulse reset asynchronously between clock edges.
  task automatic pulseReset();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int a = 0; a < 65536; a++) romMem[a] = 8'h00;
    romMem[16'h8123] = 8'h5A;
    romMem[16'h0100] = 8'h11;
    romMem[16'h0200] = 8'h22;
    romMem[16'h0101] = 8'h33;
    romMem[16'h0201] = 8'h44;
    romMem[16'h0102] = 8'h55;
    romMem[16'h0300] = 8'h66;
    romMem[16'h0400] = 8'h77;
    romMem[16'h0500] = 8'h88;
    romMem[16'h0600] = 8'h99;

    RESET  = 1'b1;
    MC_REQ = 1'b0; MC_AD = 16'h0;
    SC_REQ = 1'b0; SC_AD = 16'h0;
    DL_WR  = 1'b0; DL_AD = 16'h0; DL_DT = 8'h0;

    // Reset state
    applyStimulus(2);
    checkOutput("rst_mc_ack", 32'(MC_ACK), 32'd0);
    checkOutput("rst_sc_ack", 32'(SC_ACK), 32'd0);
    checkOutput("rst_rom_we", 32'(ROM_WE), 32'd0);
    checkOutput("rst_rom_ad", 32'(ROM_AD), 32'h0);
    checkOutput("rst_mc_dt", 32'(MC_DT), 32'h0);
    checkOutput("rst_busy", 32'(DL_BUSY), 32'd0);
    checkOutput("rst_ovf", 32'(DL_OVF), 32'd0);
    RESET = 1'b0;

    // Single MC read: address after 1 edge, ACK/data after 3, ACK drop after REQ drop
    MC_REQ = 1'b1; MC_AD = 16'h8123;
    applyStimulus(1);
    checkOutput("mc_rom_ad", 32'(ROM_AD), 32'h8123);
    MC_AD = 16'h0000;
    applyStimulus(1);
    checkOutput("mc_ack_early", 32'(MC_ACK), 32'd0);
    applyStimulus(1);
    checkOutput("mc_ack", 32'(MC_ACK), 32'd1);
    checkOutput("mc_dt", 32'(MC_DT), 32'h5A);
    applyStimulus(1);
    checkOutput("mc_ack_hold", 32'(MC_ACK), 32'd1);
    MC_REQ = 1'b0;
    applyStimulus(1);
    checkOutput("mc_ack_clr", 32'(MC_ACK), 32'd0);
    checkOutput("mc_dt_held", 32'(MC_DT), 32'h5A);

    // Tie from reset: MC first, then SC
    pulseReset();
    MC_REQ = 1'b1; MC_AD = 16'h0100;
    SC_REQ = 1'b1; SC_AD = 16'h0200;
    applyStimulus(3);
    checkOutput("tie1_mc_ack", 32'(MC_ACK), 32'd1);
    checkOutput("tie1_sc_ack", 32'(SC_ACK), 32'd0);
    checkOutput("tie1_mc_dt", 32'(MC_DT), 32'h11);
    applyStimulus(3);
    checkOutput("tie1_sc_ack2", 32'(SC_ACK), 32'd1);
    checkOutput("tie1_sc_dt", 32'(SC_DT), 32'h22);
    MC_REQ = 1'b0; SC_REQ = 1'b0;
    applyStimulus(1);
    // MC alone, so MC becomes "last"
    MC_REQ = 1'b1; MC_AD = 16'h0101;
    applyStimulus(3);
    checkOutput("solo_mc_dt", 32'(MC_DT), 32'h33);
    MC_REQ = 1'b0;
    applyStimulus(1);
    // Tie again: SC must win now
    MC_REQ = 1'b1; MC_AD = 16'h0102;
    SC_REQ = 1'b1; SC_AD = 16'h0201;
    applyStimulus(3);
    checkOutput("tie2_sc_ack", 32'(SC_ACK), 32'd1);
    checkOutput("tie2_mc_ack", 32'(MC_ACK), 32'd0);
    checkOutput("tie2_sc_dt", 32'(SC_DT), 32'h44);
    applyStimulus(3);
    checkOutput("tie2_mc_ack2", 32'(MC_ACK), 32'd1);
    checkOutput("tie2_mc_dt", 32'(MC_DT), 32'h55);
    MC_REQ = 1'b0; SC_REQ = 1'b0;
    applyStimulus(1);

    // Download arriving while an SC read is in READ
    SC_REQ = 1'b1; SC_AD = 16'h0300;
    applyStimulus(1);
    DL_WR = 1'b1; DL_AD = 16'h0010; DL_DT = 8'hC3;
    applyStimulus(1);
    DL_WR = 1'b0;
    checkOutput("dl_busy", 32'(DL_BUSY), 32'd1);
    checkOutput("dl_we_wait", 32'(ROM_WE), 32'd0);
    applyStimulus(1);
    checkOutput("dl_sc_ack", 32'(SC_ACK), 32'd1);
    checkOutput("dl_sc_dt", 32'(SC_DT), 32'h66);
    applyStimulus(1);
    checkOutput("dl_we", 32'(ROM_WE), 32'd1);
    checkOutput("dl_rom_ad", 32'(ROM_AD), 32'h0010);
    checkOutput("dl_rom_wd", 32'(ROM_WD), 32'hC3);
    checkOutput("dl_busy_clr", 32'(DL_BUSY), 32'd0);
    applyStimulus(1);
    checkOutput("dl_we_pulse", 32'(ROM_WE), 32'd0);
    SC_REQ = 1'b0;
    applyStimulus(1);

    // Two download bytes back to back while busy: second dropped
    MC_REQ = 1'b1; MC_AD = 16'h0400;
    applyStimulus(1);
    DL_WR = 1'b1; DL_AD = 16'h0020; DL_DT = 8'hA1;
    applyStimulus(1);
    DL_AD = 16'h0021; DL_DT = 8'hB2;
    applyStimulus(1);
    DL_WR = 1'b0;
    checkOutput("ovf_set", 32'(DL_OVF), 32'd1);
    checkOutput("ovf_mc_dt", 32'(MC_DT), 32'h77);
    applyStimulus(1);
    checkOutput("ovf_we", 32'(ROM_WE), 32'd1);
    checkOutput("ovf_rom_ad", 32'(ROM_AD), 32'h0020);
    checkOutput("ovf_rom_wd", 32'(ROM_WD), 32'hA1);
    applyStimulus(1);
    checkOutput("ovf_sticky", 32'(DL_OVF), 32'd1);
    checkOutput("ovf_busy", 32'(DL_BUSY), 32'd0);
    MC_REQ = 1'b0;
    applyStimulus(1);

    // Reset during CAPT of an MC read aborts it; re-served afterwards
    MC_REQ = 1'b1; MC_AD = 16'h0500;
    applyStimulus(2);
    pulseReset();
    checkOutput("abort_ack", 32'(MC_ACK), 32'd0);
    checkOutput("abort_dt", 32'(MC_DT), 32'h0);
    checkOutput("abort_ovf", 32'(DL_OVF), 32'd0);
    checkOutput("abort_rom_ad", 32'(ROM_AD), 32'h0);
    applyStimulus(1);
    checkOutput("abort_ack_e1", 32'(MC_ACK), 32'd0);
    applyStimulus(2);
    checkOutput("reserve_ack", 32'(MC_ACK), 32'd1);
    checkOutput("reserve_dt", 32'(MC_DT), 32'h88);
    MC_REQ = 1'b0;
    applyStimulus(1);

    // Pending download and MC request together: write first, ACK after 5 edges
    DL_WR = 1'b1; DL_AD = 16'h0030; DL_DT = 8'h5C;
    applyStimulus(1);
    DL_WR = 1'b0;
    MC_REQ = 1'b1; MC_AD = 16'h0600;
    applyStimulus(1);
    checkOutput("prio_we", 32'(ROM_WE), 32'd1);
    checkOutput("prio_rom_ad", 32'(ROM_AD), 32'h0030);
    applyStimulus(2);
    checkOutput("prio_mc_ad", 32'(ROM_AD), 32'h0600);
    applyStimulus(1);
    checkOutput("prio_ack_e4", 32'(MC_ACK), 32'd0);
    applyStimulus(1);
    checkOutput("prio_ack_e5", 32'(MC_ACK), 32'd1);
    checkOutput("prio_dt", 32'(MC_DT), 32'h99);
    MC_REQ = 1'b0;
    applyStimulus(1);

    // Download byte on the grant edge is loaded, no overflow
    DL_WR = 1'b1; DL_AD = 16'h0040; DL_DT = 8'hE1;
    applyStimulus(1);
    DL_AD = 16'h0041; DL_DT = 8'hE2;
    applyStimulus(1);
    DL_WR = 1'b0;
    checkOutput("same_we", 32'(ROM_WE), 32'd1);
    checkOutput("same_rom_ad", 32'(ROM_AD), 32'h0040);
    checkOutput("same_busy", 32'(DL_BUSY), 32'd1);
    checkOutput("same_ovf", 32'(DL_OVF), 32'd0);
    applyStimulus(2);
    checkOutput("same2_we", 32'(ROM_WE), 32'd1);
    checkOutput("same2_rom_ad", 32'(ROM_AD), 32'h0041);
    checkOutput("same2_rom_wd", 32'(ROM_WD), 32'hE2);
    checkOutput("same2_busy", 32'(DL_BUSY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
